// File: rtl/sha3_padder_if.sv
// ---------------------------------------------------------------------------
// sha3_padder_if
// Byte-stream input and lane-stream output bundle of the SHA3 padder.
//   in_valid/in_byte/in_keep/in_last : byte offer from the message source
//   in_ready                         : padder accepts the offered byte
//   fifo_full                        : downstream lane FIFO cannot take a write
//   wr_fifo/data_out                 : one 64-bit lane written to the FIFO
//   start                            : padded message complete, hash may begin
//   busy                             : a message is in progress
// The master modport is the message source / FIFO side, the slave modport is
// the padder itself.
// ---------------------------------------------------------------------------
interface sha3_padder_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_keep;
  logic        in_last;
  logic        in_ready;
  logic        fifo_full;
  logic        wr_fifo;
  logic [63:0] data_out;
  logic        start;
  logic        busy;

  modport master (
    output in_valid, in_byte, in_keep, in_last, fifo_full,
    input  in_ready, wr_fifo, data_out, start, busy
  );

  modport slave (
    input  in_valid, in_byte, in_keep, in_last, fifo_full,
    output in_ready, wr_fifo, data_out, start, busy
  );
endinterface

// File: rtl/sha3_padder.sv
// ---------------------------------------------------------------------------
// sha3_padder
// Packs a byte stream little-endian into 64-bit lanes, applies SHA3 pad10*1
// (0x06 after the message, 0x80 in the top byte of the last rate lane) and
// writes every lane of the padded message into a downstream FIFO, then pulses
// start for one cycle.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : sha3_padder_if.slave (byte input, lane output, status)
// Parameter:
//   RATE_LANES : 64-bit lanes per rate block (17 for SHA3-256)
// ---------------------------------------------------------------------------
module sha3_padder #(
  parameter int RATE_LANES = 17
) (
  input  logic          clk,
  input  logic          reset_n,
  sha3_padder_if.slave  bus
);

  localparam int CNT_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATE_LANES - 1);

  localparam logic [1:0] ACCUM = 2'd0;
  localparam logic [1:0] EMIT  = 2'd1;
  localparam logic [1:0] PAD   = 2'd2;
  localparam logic [1:0] START = 2'd3;

  logic [1:0]       state_r,    state_s;
  logic [63:0]      lane_r,     lane_s;
  logic [2:0]       byte_idx_r, byte_idx_s;
  logic [CNT_W-1:0] lane_cnt_r, lane_cnt_s;
  // the final message beat filled its lane: 0x06 still owed to the next lane
  logic             pad06_r,    pad06_s;

  logic [63:0]      lane_tmp_s;
  logic [3:0]       count_s;
  logic             final_s;
  logic             wr_s;
  logic [63:0]      dout_s;

  // lane counter advance, wrapping at the end of a rate block
  function automatic logic [CNT_W-1:0] lane_inc(input logic [CNT_W-1:0] c);
    if (c == LAST_LANE) begin
      return {CNT_W{1'b0}};
    end else begin
      return c + CNT_W'(1'b1);
    end
  endfunction

  // next-state, lane packing, padding and FIFO write decode
  always_comb begin
    state_s    = state_r;
    lane_s     = lane_r;
    byte_idx_s = byte_idx_r;
    lane_cnt_s = lane_cnt_r;
    pad06_s    = pad06_r;
    lane_tmp_s = lane_r;
    count_s    = {1'b0, byte_idx_r};
    final_s    = 1'b0;
    wr_s       = 1'b0;
    dout_s     = 64'd0;

    case (state_r)
      ACCUM: begin
        if (bus.in_valid) begin
          if (bus.in_keep) begin
            lane_tmp_s[{byte_idx_r, 3'b000} +: 8] = bus.in_byte;
          end else begin
            lane_tmp_s = lane_r;
          end
          // bytes held in the lane after this beat (0..8)
          count_s    = {1'b0, byte_idx_r} + {3'b000, bus.in_keep};
          byte_idx_s = count_s[2:0];
          if (bus.in_last) begin
            state_s    = PAD;
            byte_idx_s = 3'd0;
            if (count_s[3]) begin
              lane_s  = lane_tmp_s;
              pad06_s = 1'b1;
            end else begin
              lane_s  = lane_tmp_s | (64'h06 << {count_s[2:0], 3'b000});
              pad06_s = 1'b0;
            end
          end else if (count_s[3]) begin
            state_s = EMIT;
            lane_s  = lane_tmp_s;
          end else begin
            lane_s  = lane_tmp_s;
          end
        end else begin
          state_s = ACCUM;
        end
      end

      EMIT: begin
        if (!bus.fifo_full) begin
          wr_s       = 1'b1;
          dout_s     = lane_r;
          lane_s     = 64'd0;
          lane_cnt_s = lane_inc(lane_cnt_r);
          state_s    = ACCUM;
        end else begin
          state_s = EMIT;
        end
      end

      PAD: begin
        if (!bus.fifo_full) begin
          // a full message lane at the block end is data, not the final lane
          final_s    = (lane_cnt_r == LAST_LANE) && !pad06_r;
          wr_s       = 1'b1;
          dout_s     = lane_r | (final_s ? 64'h8000_0000_0000_0000 : 64'd0);
          lane_s     = pad06_r ? 64'h0000_0000_0000_0006 : 64'd0;
          pad06_s    = 1'b0;
          lane_cnt_s = lane_inc(lane_cnt_r);
          state_s    = final_s ? START : PAD;
        end else begin
          state_s = PAD;
        end
      end

      START: begin
        state_s    = ACCUM;
        lane_s     = 64'd0;
        byte_idx_s = 3'd0;
        lane_cnt_s = {CNT_W{1'b0}};
        pad06_s    = 1'b0;
      end

      default: begin
        state_s    = ACCUM;
        lane_s     = 64'd0;
        byte_idx_s = 3'd0;
        lane_cnt_s = {CNT_W{1'b0}};
        pad06_s    = 1'b0;
      end
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ACCUM;
      lane_r     <= 64'd0;
      byte_idx_r <= 3'd0;
      lane_cnt_r <= {CNT_W{1'b0}};
      pad06_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      lane_r     <= lane_s;
      byte_idx_r <= byte_idx_s;
      lane_cnt_r <= lane_cnt_s;
      pad06_r    <= pad06_s;
    end
  end

  // wr_fifo must see fifo_full in the same cycle, so it is decoded from state
  assign bus.in_ready = (state_r == ACCUM);
  assign bus.wr_fifo  = wr_s;
  assign bus.data_out = dout_s;
  assign bus.start    = (state_r == START);
  assign bus.busy     = !((state_r == ACCUM) && (byte_idx_r == 3'd0) &&
                          (lane_cnt_r == {CNT_W{1'b0}}));

endmodule

// File: tb/tb_sha3_padder.sv
// ---------------------------------------------------------------------------
// tb_sha3_padder
// Directed and randomized messages for sha3_padder. Expected lanes come from a
// byte-array model of pad10*1; a negedge monitor records FIFO writes, start
// pulses and protocol violations.
// ---------------------------------------------------------------------------
module tb_sha3_padder;
  localparam int RATE = 17;

  logic clk;
  logic reset_n;
  sha3_padder_if bus();

  sha3_padder #(.RATE_LANES(RATE)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [63:0] got_q[$];
  int          wr_cyc_q[$];
  int          start_cnt = 0;
  int          start_cyc = 0;
  int          viol      = 0;
  logic [7:0]  msg_q[$];
  logic [63:0] exp_q[$];
  bit          rand_full  = 1'b0;
  bit          force_full = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // downstream FIFO back-pressure
  always begin
    @(posedge clk);
    #1;
    bus.fifo_full = force_full ? 1'b1 :
                    (rand_full ? ($urandom_range(0, 2) == 0) : 1'b0);
  end

  // record writes, start pulses and write-while-full / stray data violations
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.wr_fifo === 1'b1) begin
        got_q.push_back(bus.data_out);
        wr_cyc_q.push_back(cyc);
        if (bus.fifo_full !== 1'b0) viol <= viol + 1;
      end else if (bus.data_out !== 64'd0) begin
        viol <= viol + 1;
      end
      if (bus.start === 1'b1) begin
        start_cnt <= start_cnt + 1;
        start_cyc <= cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // padded message as a flat byte array, then regrouped into lanes
  task automatic build_expected();
    int n;
    int total;
    logic [7:0]  pb[];
    logic [63:0] lane;
    n     = msg_q.size();
    total = RATE * 8 * (n / (RATE * 8) + 1);
    pb    = new[total];
    foreach (pb[i]) pb[i] = 8'h00;
    for (int i = 0; i < n; i++) pb[i] = msg_q[i];
    pb[n]       = pb[n] | 8'h06;
    pb[total-1] = pb[total-1] | 8'h80;
    exp_q.delete();
    for (int l = 0; l < total / 8; l++) begin
      lane = 64'd0;
      for (int k = 0; k < 8; k++) lane = lane | (64'(pb[l*8+k]) << (8 * k));
      exp_q.push_back(lane);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] b, input logic keep, input logic last);
    int guard;
    if ($urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      tick();
    end
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    bus.in_keep  = keep;
    bus.in_last  = last;
    guard = 0;
    while (bus.in_ready !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) chk("accept_timeout", 64'(guard), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_keep  = 1'b1;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input bit with_last, input bit empty_tail);
    int n;
    n = msg_q.size();
    if (n == 0) begin
      if (with_last) beat(8'h00, 1'b0, 1'b1);
    end else begin
      for (int i = 0; i < n; i++)
        beat(msg_q[i], 1'b1, with_last && !empty_tail && (i == n - 1));
      if (with_last && empty_tail) beat(8'($urandom_range(0, 255)), 1'b0, 1'b1);
    end
  endtask

  task automatic expect_msg(input string tag, input int base_w, input int base_s, input int base_v);
    int g;
    int nw;
    int m;
    build_expected();
    g = 0;
    while (start_cnt == base_s && g < 3000) begin
      tick();
      g++;
    end
    repeat (4) tick();
    nw = got_q.size() - base_w;
    chk({tag, "_nwr"}, 64'(nw), 64'(exp_q.size()));
    m = (nw < exp_q.size()) ? nw : exp_q.size();
    for (int i = 0; i < m; i++)
      chk($sformatf("%s_lane%0d", tag, i), got_q[base_w+i], exp_q[i]);
    chk({tag, "_starts"}, 64'(start_cnt - base_s), 64'd1);
    chk({tag, "_viol"}, 64'(viol - base_v), 64'd0);
    if (nw > 0) chk({tag, "_start_after_last"}, 64'(start_cyc), 64'(wr_cyc_q[base_w+nw-1] + 1));
    chk({tag, "_busy_idle"}, 64'(bus.busy), 64'd0);
    chk({tag, "_ready_idle"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int bw;
    int bs;
    int bv;
    int len;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;
    bus.in_keep  = 1'b1;
    bus.in_last  = 1'b0;
    repeat (3) tick();
    chk("rst_wr", 64'(bus.wr_fifo), 64'd0);
    chk("rst_data", bus.data_out, 64'd0);
    chk("rst_start", 64'(bus.start), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    reset_n = 1'b1;
    tick();
    chk("post_rst_ready", 64'(bus.in_ready), 64'd1);
    chk("post_rst_busy", 64'(bus.busy), 64'd0);

    // empty message: consecutive 17 writes
    msg_q.delete();
    bw = got_q.size(); bs = start_cnt; bv = viol;
    send_msg(1'b1, 1'b0);
    expect_msg("empty", bw, bs, bv);
    chk("empty_lane0", got_q[bw], 64'h0000_0000_0000_0006);
    chk("empty_lane16", got_q[bw+16], 64'h8000_0000_0000_0000);
    chk("empty_consec", 64'(wr_cyc_q[bw+16] - wr_cyc_q[bw]), 64'd16);

    // "abc"
    msg_q = '{8'h61, 8'h62, 8'h63};
    bw = got_q.size(); bs = start_cnt; bv = viol;
    send_msg(1'b1, 1'b0);
    expect_msg("abc", bw, bs, bv);
    chk("abc_lane0", got_q[bw], 64'h0000_0000_0663_6261);
    chk("abc_lane16", got_q[bw+16], 64'h8000_0000_0000_0000);

    // 135 zero bytes: 0x06 and 0x80 share the last byte
    msg_q.delete();
    repeat (135) msg_q.push_back(8'h00);
    bw = got_q.size(); bs = start_cnt; bv = viol;
    send_msg(1'b1, 1'b0);
    expect_msg("z135", bw, bs, bv);
    chk("z135_lane16", got_q[bw+16], 64'h8600_0000_0000_0000);

    // 136 zero bytes: padding needs a whole extra block
    msg_q.push_back(8'h00);
    bw = got_q.size(); bs = start_cnt; bv = viol;
    send_msg(1'b1, 1'b0);
    expect_msg("z136", bw, bs, bv);
    chk("z136_nwr", 64'(got_q.size() - bw), 64'd34);
    chk("z136_lane17", got_q[bw+17], 64'h0000_0000_0000_0006);
    chk("z136_lane33", got_q[bw+33], 64'h8000_0000_0000_0000);

    // "abc" with FIFO full for 5 cycles during padding
    msg_q = '{8'h61, 8'h62, 8'h63};
    bw = got_q.size(); bs = start_cnt; bv = viol;
    send_msg(1'b1, 1'b0);
    tick(); tick();
    force_full = 1'b1;
    repeat (5) tick();
    force_full = 1'b0;
    expect_msg("stall", bw, bs, bv);
    chk("stall_span", 64'(wr_cyc_q[bw+16] - wr_cyc_q[bw]), 64'd21);

    // reset after 10 bytes, then "abc"
    msg_q.delete();
    repeat (10) msg_q.push_back(8'($urandom_range(0, 255)));
    send_msg(1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_wr", 64'(bus.wr_fifo), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("midrst_ready", 64'(bus.in_ready), 64'd1);
    chk("midrst_busy_after", 64'(bus.busy), 64'd0);
    msg_q = '{8'h61, 8'h62, 8'h63};
    bw = got_q.size(); bs = start_cnt; bv = viol;
    send_msg(1'b1, 1'b0);
    expect_msg("rst_abc", bw, bs, bv);
    chk("rst_abc_lane0", got_q[bw], 64'h0000_0000_0663_6261);

    // random messages with random back-pressure and empty tails
    rand_full = 1'b1;
    for (int t = 0; t < 6; t++) begin
      len = (t == 0) ? 272 : $urandom_range(0, 300);
      msg_q.delete();
      for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom_range(0, 255)));
      bw = got_q.size(); bs = start_cnt; bv = viol;
      send_msg(1'b1, (t == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      expect_msg($sformatf("rnd%0d", t), bw, bs, bv);
    end
    rand_full = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
